uart_tx_fifo: RTL and testbench

Buffered UART transmitter. It consumes the byte-write strobe and data that memory_access produces for the MMIO UART address. Bytes are queued in a small FIFO and serialized as 8N1 frames on the tx pin. With the buffer, the CPU can issue several stores back-to-back without losing characters while a frame is still on the line.

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a START/DATA/STOP shifter.
// Every output is registered; tx lags the FSM state by one cycle.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rstd,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               tx,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               busy,
  output logic               overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_nxt;
  logic [BW-1:0]      baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               baud_end, push, pop, tx_nxt;

  assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
  // full is the registered flag, so a drop is decided on pre-edge occupancy
  assign push     = wr_en && !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: if (baud_end) state_nxt = DATA;
      DATA:  if (baud_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (baud_end) begin
               if (!empty) begin
                 pop       = 1'b1;
                 state_nxt = START;
               end else begin
                 state_nxt = IDLE;
               end
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // storage carries no reset; zeroed pointers make old contents unreachable
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (FIFO_AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      tx    <= tx_nxt;
      if (state == IDLE || baud_end) baud <= '0;
      else                           baud <= baud + 1'b1;
      if (state == START && baud_end)     bit_idx <= '0;
      else if (state == DATA && baud_end) bit_idx <= bit_idx + 1'b1;
      if (pop)                            shift <= mem[rd_ptr];
      else if (state == DATA && baud_end) shift <= {1'b0, shift[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo: frame-level reference model,
// tx-line decoder as monitor.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 0, rstd = 0, wr_en = 0;
  logic [7:0]    wr_data = 0;
  logic          tx, full, empty, busy, overflow;
  logic [AW:0]   count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rstd(rstd), .wr_en(wr_en), .wr_data(wr_data), .tx(tx),
    .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame in flight as a plain cycle timer.
  logic [7:0] q[$];
  logic [7:0] sb[$];
  bit m_busy = 0, m_ovf = 0;
  int m_t = 0;
  bit m_pop, m_endf, m_wasfull;

  always @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      q.delete(); sb.delete();
      m_busy = 0; m_t = 0; m_ovf = 0;
    end else begin
      m_wasfull = (q.size() == DEPTH);
      m_endf    = m_busy && (m_t == FRAME - 1);
      m_pop     = (q.size() > 0) && (!m_busy || m_endf);
      if (m_pop) begin
        sb.push_back(q.pop_front());
        m_busy = 1; m_t = 0;
      end else if (m_endf) begin
        m_busy = 0; m_t = 0;
      end else if (m_busy) m_t++;
      if (wr_en) begin
        if (m_wasfull) m_ovf = 1;
        else q.push_back(wr_data);
      end
    end
  end

  // Per-cycle flag checker
  int peak = 0;
  always @(negedge clk) begin
    if (rstd) begin
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("busy", busy, m_busy);
      chk("overflow", overflow, m_ovf);
      if (count > peak) peak = count;
    end
  end

  // Monitor: decode frames off tx and pop the scoreboard
  int starts[$];
  bit prev_tx = 1, mon_busy = 0;
  initial begin
    logic [7:0] b;
    bit ab;
    forever begin
      @(negedge clk);
      if (rstd && prev_tx && !tx) begin
        mon_busy = 1; ab = 0; b = 0;
        starts.push_back(cyc);
        for (int k = 1; k <= 38 && !ab; k++) begin
          @(negedge clk);
          if (!rstd) ab = 1;
          else if (k == 2) chk("start_bit", tx, 0);
          else if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) b[(k-6)/4] = tx;
          else if (k == 38) chk("stop_bit", tx, 1);
        end
        if (!ab) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_unexpected: got byte %02h expected none", b);
          end else chk("frame_byte", b, sb.pop_front());
        end
        mon_busy = 0;
      end
      prev_tx = tx;
    end
  end

  task automatic push(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy || q.size() != 0 || sb.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", n >= 5000, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rstd = 0;
    repeat (2) @(negedge clk);
    rstd = 1;
  endtask

  task automatic wait_t(input int t);
    int n = 0;
    while (!(m_busy && m_t == t) && n < 2000) begin @(negedge clk); n++; end
    chk("wait_timeout", n >= 2000, 0);
  endtask

  int push_cyc;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_full", full, 0); chk("rst_empty", empty, 1);
    chk("rst_count", count, 0); chk("rst_busy", busy, 0); chk("rst_ovf", overflow, 0);
    rstd = 1;
    repeat (3) @(negedge clk);

    // 1: single byte, latency
    starts.delete();
    push(8'hA5); push_cyc = cyc;
    drain();
    chk("t1_nframes", starts.size(), 1);
    if (starts.size() > 0) chk("t1_latency", starts[0] - push_cyc, 2);
    chk("t1_empty", empty, 1);

    // 2: three back-to-back bytes
    starts.delete(); peak = 0;
    push(8'h41); push(8'h42); push(8'h43);
    drain();
    chk("t2_peak", peak, 2);
    chk("t2_nframes", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("t2_gap0", starts[1] - starts[0], FRAME);
      chk("t2_gap1", starts[2] - starts[1], FRAME);
    end

    // 3: overfill while idle
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    chk("t3_full", full, 1); chk("t3_ovf", overflow, 1);
    drain();

    // 4: drop on the same edge as a STOP-end pop
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(i * 37 + 3));
    chk("t4_ovf_before", overflow, 0);
    wait_t(FRAME - 1);
    chk("t4_count_before", count, 4);
    push(8'hEE);
    chk("t4_count_after", count, 3); chk("t4_ovf_after", overflow, 1);
    drain();

    // 5: reset mid-DATA
    push(8'h5A);
    wait_t(15);
    #2 rstd = 0;
    #1;
    chk("t5_tx", tx, 1); chk("t5_busy", busy, 0);
    chk("t5_count", count, 0); chk("t5_ovf", overflow, 0);
    @(negedge clk); @(negedge clk);
    rstd = 1;
    for (int i = 0; i < 100; i++) begin @(negedge clk); chk("t5_idle_tx", tx, 1); end

    // 6: pointer wrap with 0xFF, 0x00
    for (int i = 0; i < 3; i++) begin push(8'($urandom)); drain(); end
    starts.delete();
    push(8'hFF); push(8'h00);
    drain();
    chk("t6_nframes", starts.size(), 2);
    chk("t6_empty", empty, 1);

    // random traffic with random gaps; model predicts any drops
    for (int i = 0; i < 14; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    drain();
    chk("end_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
